// File: rtl/period_gen_pkg.sv
// Shared types and defaults for the period tick generator.
// No logic; no latency; no backpressure.
package period_gen_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle timer that wraps to zero after reaching terminal_i.
// Latency: wrap_o is combinational on the current count; count updates next edge.
// Backpressure: none; enable_i gates counting, clear_i forces zero.
module cycle_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] terminal_i,
    output logic             wrap_o
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_terminal;

    assign w_at_terminal = (r_count == terminal_i);
    assign wrap_o        = enable_i && w_at_terminal;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_count <= '0;
        end else if (enable_i) begin
            r_count <= w_at_terminal ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/period_tick_generator.sv
// Programmable tick source: bursts or continuous one-cycle ticks spaced period_i clocks apart.
// Latency: first tick one cycle after the accepting edge; done_o one cycle after the last tick.
// Backpressure: none; start_i is ignored while busy, stop_i aborts a run at the next edge.
module period_tick_generator
    import period_gen_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [WIDTH-1:0]     period_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic                 tick_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] ticks_sent_o
);

    localparam logic [WIDTH-1:0]     MIN_P   = WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_period_q;
    logic [CNT_WIDTH-1:0] r_count_q;
    logic [CNT_WIDTH-1:0] r_ticks_sent;
    logic                 r_tick;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_timer_clear;
    logic                 w_timer_en;
    logic                 w_wrap;
    logic [WIDTH-1:0]     w_terminal;
    logic [CNT_WIDTH-1:0] w_sent_next;

    // Timer only advances in RUN; a stop clears it so a later run starts aligned.
    assign w_timer_en    = (r_state == RUN) && !stop_i;
    assign w_timer_clear = !w_timer_en;
    assign w_terminal    = r_period_q - WIDTH'(1);
    assign w_sent_next   = (r_ticks_sent == CNT_MAX) ? r_ticks_sent
                                                     : r_ticks_sent + CNT_WIDTH'(1);

    cycle_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (w_timer_clear),
        .enable_i   (w_timer_en),
        .terminal_i (w_terminal),
        .wrap_o     (w_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_period_q   <= MIN_P;
            r_count_q    <= '0;
            r_ticks_sent <= '0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        if (period_i < MIN_P) begin
                            r_error <= 1'b1;
                        end else begin
                            r_period_q   <= period_i;
                            r_count_q    <= count_i;
                            r_tick       <= 1'b1;
                            r_ticks_sent <= CNT_WIDTH'(1);
                            r_busy       <= 1'b1;
                            // A one-tick burst is already complete at accept.
                            r_state      <= (count_i == CNT_WIDTH'(1)) ? FINISH : RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_wrap) begin
                        r_tick       <= 1'b1;
                        r_ticks_sent <= w_sent_next;
                        if ((r_count_q != '0) && (w_sent_next == r_count_q)) begin
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tick_o       = r_tick;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign ticks_sent_o = r_ticks_sent;

endmodule
